// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: two per-source result FIFOs, round-robin grant, one registered broadcast per cycle.
// Optional same-cycle bypass of an empty FIFO is enabled by defining CDB_BYPASS_EN.
`ifndef ROB_WIDTH
`define ROB_WIDTH 4
`endif

module cdb_arbiter #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned FIFO_WIDTH = 2,
  parameter int unsigned ROB_W      = `ROB_WIDTH
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             flush,
  input  logic             alu_rdy,
  input  logic [ROB_W-1:0] alu_rob_id,
  input  logic [31:0]      alu_data,
  input  logic             alu_set_jump_addr,
  output logic             alu_stall,
  input  logic             lsb_rdy,
  input  logic [ROB_W-1:0] lsb_rob_id,
  input  logic [31:0]      lsb_data,
  output logic             lsb_stall,
  output logic             cdb_en,
  output logic [ROB_W-1:0] cdb_rob_id,
  output logic [31:0]      cdb_data,
  output logic             cdb_set_jump_addr,
  output logic             cdb_src
);

  localparam int unsigned ENT_W = ROB_W + 33;
  localparam int unsigned CNT_W = FIFO_WIDTH + 1;

  typedef enum logic {SRC_ALU = 1'b0, SRC_LSB = 1'b1} src_e;

  logic [ENT_W-1:0]      mem_q [2][FIFO_DEPTH];
  logic [FIFO_WIDTH-1:0] head_q [2];
  logic [FIFO_WIDTH-1:0] tail_q [2];
  logic [CNT_W-1:0]      cnt_q  [2];
  logic [CNT_W-1:0]      cnt_d  [2];
  src_e                  last_grant_q;

  logic [ENT_W-1:0] in_ent   [2];
  logic [ENT_W-1:0] head_ent [2];
  logic [1:0]       in_rdy;
  logic [1:0]       nonempty;
  logic [1:0]       head_v;
  logic [1:0]       gnt;
  logic [1:0]       pop;
  logic [1:0]       wr;
  logic [ENT_W-1:0] gnt_ent;

  assign alu_stall = (cnt_q[0] >= CNT_W'(FIFO_DEPTH - 1));
  assign lsb_stall = (cnt_q[1] >= CNT_W'(FIFO_DEPTH - 1));

  // Heads, grant, and per-FIFO push/pop decisions for this cycle.
  always_comb begin
    in_rdy    = {lsb_rdy, alu_rdy};
    in_ent[0] = {alu_set_jump_addr, alu_rob_id, alu_data};
    in_ent[1] = {1'b0, lsb_rob_id, lsb_data};
    for (int s = 0; s < 2; s++) begin
      nonempty[s] = (cnt_q[s] != '0);
      head_v[s]   = nonempty[s];
      head_ent[s] = mem_q[s][head_q[s]];
`ifdef CDB_BYPASS_EN
      if (!nonempty[s] && in_rdy[s]) begin
        head_v[s]   = 1'b1;
        head_ent[s] = in_ent[s];
      end
`endif
    end
    gnt[0]  = head_v[0] && (!head_v[1] || (last_grant_q == SRC_LSB));
    gnt[1]  = head_v[1] && !gnt[0];
    gnt_ent = gnt[1] ? head_ent[1] : head_ent[0];
    for (int s = 0; s < 2; s++) begin
      pop[s]   = gnt[s] && nonempty[s];
      // A granted bypass input goes straight to the bus and never enters the FIFO.
      wr[s]    = in_rdy[s] && !(gnt[s] && !nonempty[s]) &&
                 ((cnt_q[s] != CNT_W'(FIFO_DEPTH)) || pop[s]);
      cnt_d[s] = cnt_q[s] + CNT_W'(wr[s]) - CNT_W'(pop[s]);
    end
  end

  // Control state and broadcast registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int s = 0; s < 2; s++) begin
        cnt_q[s]  <= '0;
        head_q[s] <= '0;
        tail_q[s] <= '0;
      end
      cdb_en            <= 1'b0;
      cdb_rob_id        <= '0;
      cdb_data          <= '0;
      cdb_set_jump_addr <= 1'b0;
      cdb_src           <= 1'b0;
      last_grant_q      <= SRC_LSB;
    end else if (rdy_in) begin
      if (flush) begin
        for (int s = 0; s < 2; s++) begin
          cnt_q[s]  <= '0;
          head_q[s] <= '0;
          tail_q[s] <= '0;
        end
        cdb_en <= 1'b0;
      end else begin
        for (int s = 0; s < 2; s++) begin
          cnt_q[s]  <= cnt_d[s];
          head_q[s] <= head_q[s] + FIFO_WIDTH'(pop[s]);
          tail_q[s] <= tail_q[s] + FIFO_WIDTH'(wr[s]);
        end
        cdb_en <= |gnt;
        if (|gnt) begin
          {cdb_set_jump_addr, cdb_rob_id, cdb_data} <= gnt_ent;
          cdb_src      <= gnt[1];
          last_grant_q <= gnt[1] ? SRC_LSB : SRC_ALU;
        end
      end
    end
  end

  // FIFO storage needs no reset; occupancy is tracked by the counters.
  always_ff @(posedge clk_in) begin
    if (!rst_in && rdy_in && !flush) begin
      for (int s = 0; s < 2; s++) begin
        if (wr[s]) mem_q[s][tail_q[s]] <= in_ent[s];
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter (default build): table of per-cycle stimulus with hand-derived expected outputs.
module tb_cdb_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, flush;
  logic        alu_rdy, alu_set_jump_addr, alu_stall;
  logic [3:0]  alu_rob_id;
  logic [31:0] alu_data;
  logic        lsb_rdy, lsb_stall;
  logic [3:0]  lsb_rob_id;
  logic [31:0] lsb_data;
  logic        cdb_en, cdb_set_jump_addr, cdb_src;
  logic [3:0]  cdb_rob_id;
  logic [31:0] cdb_data;

  cdb_arbiter #(.FIFO_DEPTH(4), .FIFO_WIDTH(2), .ROB_W(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
    .alu_rdy(alu_rdy), .alu_rob_id(alu_rob_id), .alu_data(alu_data),
    .alu_set_jump_addr(alu_set_jump_addr), .alu_stall(alu_stall),
    .lsb_rdy(lsb_rdy), .lsb_rob_id(lsb_rob_id), .lsb_data(lsb_data), .lsb_stall(lsb_stall),
    .cdb_en(cdb_en), .cdb_rob_id(cdb_rob_id), .cdb_data(cdb_data),
    .cdb_set_jump_addr(cdb_set_jump_addr), .cdb_src(cdb_src)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [2:0]  ctl;   // {rst, rdy, flush}
    logic [1:0]  a;     // {alu_rdy, alu_set_jump_addr}
    logic [3:0]  at;
    logic [31:0] ad;
    logic        lr;
    logic [3:0]  lt;
    logic [31:0] ld;
    logic [3:0]  ef;    // {check all fields, en, src, jump}
    logic [3:0]  et;
    logic [31:0] ed;
    logic [1:0]  st;    // {alu_stall, lsb_stall}
  } vec_t;

  localparam logic [2:0] RUN = 3'b010, RST = 3'b110, FLU = 3'b011, HLD = 3'b000, HLF = 3'b001;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   n_pass = 0, n_total = 0;

  function automatic vec_t v(input logic [2:0] ctl, input logic [1:0] a, input logic [3:0] at,
                             input logic [31:0] ad, input logic lr, input logic [3:0] lt,
                             input logic [31:0] ld, input logic [3:0] ef, input logic [3:0] et,
                             input logic [31:0] ed, input logic [1:0] st);
    vec_t r;
    r.ctl = ctl; r.a = a; r.at = at; r.ad = ad; r.lr = lr; r.lt = lt; r.ld = ld;
    r.ef = ef; r.et = et; r.ed = ed; r.st = st;
    return r;
  endfunction

  function automatic vec_t idle(input logic [3:0] ef, input logic [3:0] et, input logic [31:0] ed,
                                input logic [1:0] st);
    return v(RUN, 2'b00, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, ef, et, ed, st);
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s row %0d: got 0x%0h required 0x%0h", name, idx, act, exp);
  endtask

  initial begin
    vec_t rr, e;
    logic prev_as, prev_ls;
    rr = v(RST, 2'b00, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 4'b1000, 4'd0, 32'd0, 2'b00);

    // Single ALU result: two-cycle latency, then bus idle.
    vecs.push_back(rr);
    vecs.push_back(v(RUN, 2'b10, 4'd3, 32'h55, 1'b0, 4'd0, 32'd0, 4'b0000, 4'd0, 32'd0, 2'b00));
    vecs.push_back(idle(4'b0100, 4'd3, 32'h55, 2'b00));
    vecs.push_back(idle(4'b0000, 4'd0, 32'd0, 2'b00));

    // Both sources backlogged, pushing whenever not stalled: strict alternation, per-source order.
    vecs.push_back(rr);
    vecs.push_back(v(RUN, 2'b10, 4'd0, 32'hA0, 1'b1, 4'd8,  32'hB0, 4'b0000, 4'd0,  32'd0,  2'b00));
    vecs.push_back(v(RUN, 2'b10, 4'd1, 32'hA1, 1'b1, 4'd9,  32'hB1, 4'b0100, 4'd0,  32'hA0, 2'b00));
    vecs.push_back(v(RUN, 2'b10, 4'd2, 32'hA2, 1'b1, 4'd10, 32'hB2, 4'b0110, 4'd8,  32'hB0, 2'b00));
    vecs.push_back(v(RUN, 2'b10, 4'd3, 32'hA3, 1'b1, 4'd11, 32'hB3, 4'b0100, 4'd1,  32'hA1, 2'b01));
    vecs.push_back(v(RUN, 2'b10, 4'd4, 32'hA4, 1'b0, 4'd0,  32'd0,  4'b0110, 4'd9,  32'hB1, 2'b10));
    vecs.push_back(v(RUN, 2'b00, 4'd0, 32'd0,  1'b1, 4'd12, 32'hB4, 4'b0100, 4'd2,  32'hA2, 2'b01));
    vecs.push_back(v(RUN, 2'b10, 4'd5, 32'hA5, 1'b0, 4'd0,  32'd0,  4'b0110, 4'd10, 32'hB2, 2'b10));
    vecs.push_back(v(RUN, 2'b00, 4'd0, 32'd0,  1'b1, 4'd13, 32'hB5, 4'b0100, 4'd3,  32'hA3, 2'b01));
    vecs.push_back(idle(4'b0110, 4'd11, 32'hB3, 2'b00));
    vecs.push_back(idle(4'b0100, 4'd4,  32'hA4, 2'b00));
    vecs.push_back(idle(4'b0110, 4'd12, 32'hB4, 2'b00));
    vecs.push_back(idle(4'b0100, 4'd5,  32'hA5, 2'b00));
    vecs.push_back(idle(4'b0110, 4'd13, 32'hB5, 2'b00));
    vecs.push_back(idle(4'b0000, 4'd0,  32'd0,  2'b00));

    // Flush with two entries queued per source and new pushes in the flush cycle.
    vecs.push_back(rr);
    vecs.push_back(v(RUN, 2'b10, 4'd1, 32'h11, 1'b1, 4'd9,  32'h91, 4'b0000, 4'd0, 32'd0,  2'b00));
    vecs.push_back(v(RUN, 2'b10, 4'd2, 32'h12, 1'b1, 4'd10, 32'h92, 4'b0100, 4'd1, 32'h11, 2'b00));
    vecs.push_back(v(RUN, 2'b10, 4'd3, 32'h13, 1'b1, 4'd11, 32'h93, 4'b0110, 4'd9, 32'h91, 2'b00));
    vecs.push_back(v(FLU, 2'b10, 4'd4, 32'h14, 1'b1, 4'd12, 32'h94, 4'b0000, 4'd0, 32'd0,  2'b00));
    vecs.push_back(idle(4'b0000, 4'd0, 32'd0, 2'b00));
    vecs.push_back(idle(4'b0000, 4'd0, 32'd0, 2'b00));
    vecs.push_back(v(RUN, 2'b10, 4'd5, 32'h15, 1'b0, 4'd0, 32'd0, 4'b0000, 4'd0, 32'd0, 2'b00));
    vecs.push_back(idle(4'b0100, 4'd5, 32'h15, 2'b00));
    vecs.push_back(idle(4'b0000, 4'd0, 32'd0,  2'b00));

    // rdy_in low for three cycles: bus frozen, spurious pushes and flush ignored.
    vecs.push_back(rr);
    vecs.push_back(v(RUN, 2'b10, 4'd1,  32'h1001, 1'b1, 4'd9,  32'h9001, 4'b0000, 4'd0, 32'd0,    2'b00));
    vecs.push_back(v(RUN, 2'b10, 4'd2,  32'h1002, 1'b1, 4'd10, 32'h9002, 4'b0100, 4'd1, 32'h1001, 2'b00));
    vecs.push_back(v(HLD, 2'b10, 4'd15, 32'hFFFF, 1'b1, 4'd14, 32'hEEEE, 4'b1100, 4'd1, 32'h1001, 2'b00));
    vecs.push_back(v(HLF, 2'b00, 4'd0,  32'd0,    1'b0, 4'd0,  32'd0,    4'b1100, 4'd1, 32'h1001, 2'b00));
    vecs.push_back(v(HLD, 2'b00, 4'd0,  32'd0,    1'b0, 4'd0,  32'd0,    4'b1100, 4'd1, 32'h1001, 2'b00));
    vecs.push_back(idle(4'b0110, 4'd9,  32'h9001, 2'b00));
    vecs.push_back(idle(4'b0100, 4'd2,  32'h1002, 2'b00));
    vecs.push_back(idle(4'b0110, 4'd10, 32'h9002, 2'b00));
    vecs.push_back(idle(4'b0000, 4'd0,  32'd0,    2'b00));

    // Jump flag: LSB never carries it, ALU does; then reset in the middle of a backlog.
    vecs.push_back(rr);
    vecs.push_back(v(RUN, 2'b01, 4'd0, 32'd0,  1'b1, 4'd7, 32'h77, 4'b0000, 4'd0, 32'd0,  2'b00));
    vecs.push_back(idle(4'b0110, 4'd7, 32'h77, 2'b00));
    vecs.push_back(v(RUN, 2'b11, 4'd6, 32'h66, 1'b0, 4'd0, 32'd0,  4'b0000, 4'd0, 32'd0,  2'b00));
    vecs.push_back(idle(4'b0101, 4'd6, 32'h66, 2'b00));
    vecs.push_back(v(RUN, 2'b10, 4'd1, 32'h1,  1'b1, 4'd2, 32'h2,  4'b0000, 4'd0, 32'd0,  2'b00));
    vecs.push_back(v(RUN, 2'b10, 4'd3, 32'h3,  1'b1, 4'd4, 32'h4,  4'b0110, 4'd2, 32'h2,  2'b00));
    vecs.push_back(rr);
    vecs.push_back(idle(4'b0000, 4'd0, 32'd0, 2'b00));
    vecs.push_back(v(RUN, 2'b10, 4'd5, 32'h5,  1'b1, 4'd6, 32'h6,  4'b0000, 4'd0, 32'd0,  2'b00));
    vecs.push_back(idle(4'b0100, 4'd5, 32'h5, 2'b00));
    vecs.push_back(idle(4'b0110, 4'd6, 32'h6, 2'b00));
    vecs.push_back(idle(4'b0000, 4'd0, 32'd0, 2'b00));

    prev_as = 1'b0;
    prev_ls = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk_in);
      {rst_in, rdy_in, flush} = vecs[i].ctl;
      {alu_rdy, alu_set_jump_addr} = vecs[i].a;
      alu_rob_id = vecs[i].at; alu_data = vecs[i].ad;
      lsb_rdy = vecs[i].lr; lsb_rob_id = vecs[i].lt; lsb_data = vecs[i].ld;
      exp_q.push_back(vecs[i]);
      // A source may only push while its registered stall is low.
      if (!rst_in && rdy_in && !flush && alu_rdy) chk("alu_push_legal", i, 32'(prev_as), 32'd0);
      if (!rst_in && rdy_in && !flush && lsb_rdy) chk("lsb_push_legal", i, 32'(prev_ls), 32'd0);
      @(posedge clk_in);
      #1;
      e = exp_q.pop_front();
      chk("cdb_en",    i, 32'(cdb_en),    32'(e.ef[2]));
      chk("alu_stall", i, 32'(alu_stall), 32'(e.st[1]));
      chk("lsb_stall", i, 32'(lsb_stall), 32'(e.st[0]));
      if (e.ef[3] || e.ef[2]) begin
        chk("cdb_rob_id",        i, 32'(cdb_rob_id),        32'(e.et));
        chk("cdb_data",          i, cdb_data,               e.ed);
        chk("cdb_src",           i, 32'(cdb_src),           32'(e.ef[1]));
        chk("cdb_set_jump_addr", i, 32'(cdb_set_jump_addr), 32'(e.ef[0]));
      end
      prev_as = alu_stall;
      prev_ls = lsb_stall;
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
